// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input path: reader state encoding, default
// widths and the sample FIFO depth used by both the write and read controllers.
package fft_pkg;

   localparam int DATA_W_DEF    = 32;
   localparam int USEDW_W_DEF   = 5;
   localparam int FRAME_LEN_DEF = 16;
   localparam int FIFO_DEPTH    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/fft_skid2.sv
// Two-entry, order-preserving register buffer that soaks up the FIFO's read
// latency; head drives dout and occ reports how many entries are held.
module fft_skid2
   import fft_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              iRst,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic [1:0]        occ
);

   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] tail;

   assign dout = head;

   always_ff @(posedge clk or posedge iRst) begin
      if (iRst) begin
         head <= '0;
         tail <= '0;
         occ  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) head <= din;
               else             tail <= din;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            // Simultaneous push and pop: the new word lands behind whatever stays.
            2'b11: begin
               if (occ == 2'd2) begin
                  head <= tail;
                  tail <= din;
               end else begin
                  head <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fft_frame_reader.sv
// Read-side controller for the FFT sample FIFO: waits for a whole frame, reads
// it out and presents it to the FFT sink as a valid/sop/eop stream.
module fft_frame_reader
   import fft_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int USEDW_W   = USEDW_W_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF
) (
   input  logic               clk,
   input  logic               iRst,
   input  logic [USEDW_W-1:0] iUsedW,
   input  logic               iEmpty,
   input  logic [DATA_W-1:0]  iQ,
   output logic               oRdreq,
   output logic [DATA_W-1:0]  oData,
   output logic               oValid,
   output logic               oSop,
   output logic               oEop,
   input  logic               iReady,
   output logic               oUnderrun
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(FRAME_LEN - 1);
   localparam logic [USEDW_W-1:0] START_LVL = USEDW_W'(FRAME_LEN);

   state_t           state;
   state_t           stateNext;
   logic [CNT_W-1:0] rdCnt;
   logic [CNT_W-1:0] outCnt;
   logic             pend;
   logic [1:0]       occ;
   logic             pop;
   logic [2:0]       inFlight;
   logic             credit;
   logic             wantRead;

   // Sink handshake: a word moves when oValid & iReady; while oValid & ~iReady
   // oData, oSop and oEop are held unchanged.
   assign pop      = oValid & iReady;
   assign oValid   = (occ != 2'd0);
   assign inFlight = {1'b0, occ} + {2'b00, pend};
   // A read may issue only if its word will find a free skid slot.
   assign credit   = inFlight < (3'd2 + {2'b00, pop});
   assign wantRead = (state == FETCH) && (rdCnt < CNT_FULL);
   assign oRdreq   = wantRead & ~iEmpty & credit;
   assign oSop     = oValid & (outCnt == '0);
   assign oEop     = oValid & (outCnt == CNT_LAST);

   fft_skid2 #(
      .DATA_W (DATA_W)
   ) skid (
      .clk  (clk),
      .iRst (iRst),
      .push (pend),
      .din  (iQ),
      .pop  (pop),
      .dout (oData),
      .occ  (occ)
   );

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (iUsedW >= START_LVL)         stateNext = FETCH;
         FETCH:   if (oRdreq && rdCnt == CNT_LAST) stateNext = DRAIN;
         DRAIN:   if (pop && oEop)                 stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge iRst) begin
      if (iRst) begin
         state     <= IDLE;
         rdCnt     <= '0;
         outCnt    <= '0;
         pend      <= 1'b0;
         oUnderrun <= 1'b0;
      end else begin
         state <= stateNext;
         pend  <= oRdreq;
         if (state == IDLE) begin
            rdCnt  <= '0;
            outCnt <= '0;
         end else begin
            if (oRdreq) rdCnt  <= rdCnt + CNT_W'(1);
            if (pop)    outCnt <= outCnt + CNT_W'(1);
         end
         // Starved mid-frame: flag it and simply wait for more data.
         if (wantRead && iEmpty && credit) oUnderrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fft_frame_reader.sv
// Bench for fft_frame_reader: a queue-based FIFO model feeds the reader and a
// per-cycle compare process checks the framed stream against the words read.
module tb_fft_frame_reader;

   localparam int DW = 32;
   localparam int UW = 5;
   localparam int FL = 16;

   logic          clk;
   logic          iRst;
   logic [UW-1:0] iUsedW;
   logic          iEmpty;
   logic [DW-1:0] iQ;
   logic          oRdreq;
   logic [DW-1:0] oData;
   logic          oValid;
   logic          oSop;
   logic          oEop;
   logic          iReady;
   logic          oUnderrun;

   fft_frame_reader #(
      .DATA_W    (DW),
      .USEDW_W   (UW),
      .FRAME_LEN (FL)
   ) dut (
      .clk       (clk),
      .iRst      (iRst),
      .iUsedW    (iUsedW),
      .iEmpty    (iEmpty),
      .iQ        (iQ),
      .oRdreq    (oRdreq),
      .oData     (oData),
      .oValid    (oValid),
      .oSop      (oSop),
      .oEop      (oEop),
      .iReady    (iReady),
      .oUnderrun (oUnderrun)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int            nCmp = 0;
   int            nBad = 0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   int            sopCyc[$];
   int            eopCyc[$];
   int            rdTotal  = 0;
   int            eopCount = 0;
   int            cycNo    = 0;
   bit            readyRand  = 1'b0;
   bit            forceEmpty = 1'b0;
   logic          rdAtEdge = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] got_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return 'x;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic update_flags();
      iUsedW = (fifo_q.size() > 31) ? 5'd31 : UW'(fifo_q.size());
      iEmpty = (fifo_q.size() == 0) || forceEmpty;
   endtask

   task automatic preload(input logic [DW-1:0] first, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(first + DW'(i));
      update_flags();
   endtask

   // One clock: drive sink/FIFO inputs at negedge, model the FIFO read after posedge.
   task automatic cycle();
      @(negedge clk);
      iReady = readyRand ? 1'($urandom_range(0, 1)) : 1'b1;
      iEmpty = (fifo_q.size() == 0) || forceEmpty;
      #4;
      rdAtEdge = oRdreq;
      @(posedge clk);
      #1;
      if (rdAtEdge && fifo_q.size() != 0) begin
         iQ = fifo_q.pop_front();
         exp_q.push_back(iQ);
         rdTotal++;
      end
      update_flags();
   endtask

   task automatic run_to_eops(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (eopCount < target && n < budget) begin
         cycle();
         n++;
      end
      check({tag, "_eop_timeout"}, eopCount, target);
   endtask

   // ---------------- compare process ----------------
   int            wpos      = 0;
   int            rdInFrame = 0;
   bit            prevStall = 1'b0;
   bit            prevEopPop = 1'b0;
   bit            prevUnder = 1'b0;
   logic [DW-1:0] prevData;
   logic          prevSop;
   logic          prevEop;

   always begin
      logic [DW-1:0] ew;
      @(negedge clk);
      #1;
      cycNo++;
      if (iRst) begin
         check("rst_rdreq", oRdreq, 0);
         check("rst_valid", oValid, 0);
         check("rst_sop", oSop, 0);
         check("rst_eop", oEop, 0);
         check("rst_underrun", oUnderrun, 0);
         check("rst_data", oData, 0);
         wpos = 0; rdInFrame = 0;
         prevStall = 1'b0; prevEopPop = 1'b0; prevUnder = 1'b0;
      end else begin
         if (oRdreq) begin
            check("rdreq_while_empty", iEmpty, 0);
            check("rdreq_beyond_frame", rdInFrame < FL, 1);
            rdInFrame++;
         end
         check("held_words_le_2", exp_q.size() <= 2, 1);
         if (oValid) check("valid_without_word", exp_q.size() != 0, 1);
         else begin
            check("sop_without_valid", oSop, 0);
            check("eop_without_valid", oEop, 0);
         end
         if (prevEopPop) begin
            check("gap_rdreq", oRdreq, 0);
            check("gap_valid", oValid, 0);
         end
         if (prevStall) begin
            check("stall_valid", oValid, 1);
            check("stall_data", oData, prevData);
            check("stall_sop", oSop, prevSop);
            check("stall_eop", oEop, prevEop);
         end
         if (prevUnder) check("underrun_sticky", oUnderrun, 1);
         prevEopPop = 1'b0;
         if (oValid && iReady) begin
            ew = 'x;
            if (exp_q.size() != 0) ew = exp_q.pop_front();
            check("data_order", oData, ew);
            check("sop_pos", oSop, wpos == 0);
            check("eop_pos", oEop, wpos == FL - 1);
            got_q.push_back(oData);
            if (wpos == 0) sopCyc.push_back(cycNo);
            if (wpos == FL - 1) begin
               check("frame_reads_at_eop", rdInFrame, FL);
               eopCyc.push_back(cycNo);
               eopCount++;
               wpos = 0;
               rdInFrame = 0;
               prevEopPop = 1'b1;
            end else begin
               wpos++;
            end
         end
         prevStall = oValid & ~iReady;
         prevData  = oData;
         prevSop   = oSop;
         prevEop   = oEop;
         prevUnder = oUnderrun;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int            base;
      logic [DW-1:0] rnd[FL];
      logic [DW-1:0] first;
      int            n;

      iRst = 1'b1; iUsedW = '0; iEmpty = 1'b1; iQ = '0; iReady = 1'b1;
      repeat (3) cycle();
      check("reset_valid", oValid, 0);
      check("reset_rdreq", oRdreq, 0);
      check("reset_data", oData, 0);
      iRst = 1'b0;
      repeat (2) cycle();

      // Frame 0..15 with the sink always ready.
      got_q.delete(); base = rdTotal;
      preload(0, FL);
      run_to_eops(eopCount + 1, 100, "t1");
      check("t1_words", got_q.size(), FL);
      for (int i = 0; i < FL; i++) check($sformatf("t1_word%0d", i), got_at(i), DW'(i));
      check("t1_rdreq_pulses", rdTotal - base, FL);
      check("t1_span", eopCyc[$] - sopCyc[$], FL - 1);
      repeat (3) cycle();
      check("t1_underrun", oUnderrun, 0);
      check("t1_idle_valid", oValid, 0);

      // Fifteen words never start a frame; the sixteenth does one cycle later.
      got_q.delete(); base = rdTotal;
      preload(20, FL - 1);
      repeat (20) cycle();
      check("t2_no_read_at_15", rdTotal - base, 0);
      fifo_q.push_back(35);
      update_flags();
      cycle();
      check("t2_latency_t", rdAtEdge, 0);
      cycle();
      check("t2_latency_t1", rdAtEdge, 1);
      run_to_eops(eopCount + 1, 100, "t2");
      for (int i = 0; i < FL; i++) check($sformatf("t2_word%0d", i), got_at(i), DW'(20 + i));

      // Random data, random back-pressure.
      got_q.delete();
      for (int i = 0; i < FL; i++) begin
         rnd[i] = $urandom;
         fifo_q.push_back(rnd[i]);
      end
      update_flags();
      readyRand = 1'b1;
      run_to_eops(eopCount + 1, 400, "t3");
      readyRand = 1'b0;
      check("t3_words", got_q.size(), FL);
      for (int i = 0; i < FL; i++) check($sformatf("t3_word%0d", i), got_at(i), rnd[i]);

      // FIFO reports empty for 5 cycles after 8 reads.
      got_q.delete(); base = rdTotal;
      preload(200, FL);
      n = 0;
      while (rdTotal - base < 8 && n < 100) begin
         cycle();
         n++;
      end
      check("t4_underrun_before", oUnderrun, 0);
      forceEmpty = 1'b1;
      update_flags();
      repeat (5) cycle();
      forceEmpty = 1'b0;
      update_flags();
      check("t4_underrun_set", oUnderrun, 1);
      run_to_eops(eopCount + 1, 100, "t4");
      check("t4_words", got_q.size(), FL);
      for (int i = 0; i < FL; i++) check($sformatf("t4_word%0d", i), got_at(i), DW'(200 + i));
      check("t4_underrun_held", oUnderrun, 1);

      // 32 words: two back-to-back frames.
      got_q.delete();
      preload(300, 2 * FL);
      run_to_eops(eopCount + 2, 200, "t5");
      check("t5_words", got_q.size(), 2 * FL);
      for (int i = 0; i < 2 * FL; i++) check($sformatf("t5_word%0d", i), got_at(i), DW'(300 + i));
      check("t5_span0", eopCyc[$-1] - sopCyc[$-1], FL - 1);
      check("t5_span1", eopCyc[$] - sopCyc[$], FL - 1);
      check("t5_gap", (sopCyc[$] - eopCyc[$-1]) >= 2, 1);

      // Reset mid-frame after word 5.
      got_q.delete(); base = rdTotal;
      preload(500, 2 * FL);
      n = 0;
      while (got_q.size() < 6 && n < 100) begin
         cycle();
         n++;
      end
      check("t6_reach_word5", got_q.size(), 6);
      @(negedge clk);
      #3;
      iRst = 1'b1;
      exp_q.delete();
      #1;
      check("t6_async_rdreq", oRdreq, 0);
      check("t6_async_valid", oValid, 0);
      check("t6_async_sop", oSop, 0);
      check("t6_async_eop", oEop, 0);
      check("t6_async_underrun", oUnderrun, 0);
      check("t6_async_data", oData, 0);
      repeat (2) cycle();
      iRst = 1'b0;
      got_q.delete();
      first = DW'(500 + rdTotal - base);
      run_to_eops(eopCount + 1, 100, "t6");
      check("t6_words", got_q.size(), FL);
      for (int i = 0; i < FL; i++) check($sformatf("t6_word%0d", i), got_at(i), first + DW'(i));
      check("t6_underrun_after", oUnderrun, 0);
      repeat (10) cycle();
      check("t6_tail_idle", oValid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
